// File: rtl/pipe_reg_param_pkg.sv
// Shared definitions for the parameterised valid/ready register pipeline.
// Holds the constant width helper used to size the occupancy counter.
package pipe_reg_param_pkg;

  // Ceiling log2 with a floor of 1, so that every derived port is at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_param_stage.sv
// One pipeline stage: a valid flag plus a write-enabled data register.
// Both are cleared to their reset values asynchronously by an active-high reset.
module pipe_stage
  import pipe_reg_param_pkg::*;
#(
  parameter int              WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] d_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: sequential state uses non-blocking assignments so that every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (advance) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the data register is reset as well, so a freshly reset pipeline shows RST_VAL on out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= RST_VAL;
    end else if (load) begin
      data <= d_in;
    end
  end

endmodule

// File: rtl/pipe_reg_param.sv
// Parameterised valid/ready register pipeline with bubble collapse, flush and occupancy count.
// The last stage drives out_valid/out_data directly; only the ready chain is combinational.
module pipe_reg_param
  import pipe_reg_param_pkg::*;
#(
  parameter int               WIDTH   = 2,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  d [STAGES];

  // Walk from the output side back: 'room' is true when the stage below can take a new item.
  // NOTE: every variable driven here receives a default first, so no latch is inferred.
  always_comb begin
    logic room;
    adv  = '0;
    load = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = v[i] & room;
      room   = ~v[i] | adv[i];
    end
    in_ready = room & ~flush;
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1] & ~flush;
    end
  end

  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] d_src;
    if (g == 0) begin : g_src_in
      assign d_src = in_data;
    end else begin : g_src_prev
      assign d_src = d[g-1];
    end

    pipe_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (load[g]),
      .advance(adv[g]),
      .d_in   (d_src),
      .valid  (v[g]),
      .data   (d[g])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Population count of the registered valid flags; resets with them.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + CW'(v[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_param.sv
// Directed and randomised checks of pipe_reg_param with WIDTH=8, STAGES=3.
module tb_pipe_reg_param;

  localparam int         WIDTH   = 8;
  localparam int         STAGES  = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;
  localparam int         CW      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_item;

  pipe_reg_param #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'(RST_VAL));
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    // Three back-to-back items with the sink always ready: first one appears after three edges.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    check("lat_valid_c3", 32'(out_valid), 32'd1);
    check("lat_data_11",  32'(out_data),  32'h11);
    tick();
    check("lat_data_22",  32'(out_data),  32'h22);
    check("lat_valid_22", 32'(out_valid), 32'd1);
    tick();
    check("lat_data_33",  32'(out_data),  32'h33);
    tick();
    check("lat_empty",    32'(out_valid), 32'd0);
    check("lat_occ0",     32'(occupancy), 32'd0);

    // Stalled sink: three items fill the pipe, the fourth waits, then enters as the head leaves.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h41; #1;
    check("stall_ready_empty", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h42; tick();
    in_data = 8'h43; tick();
    in_data = 8'h44; #1;
    check("full_occ",       32'(occupancy), 32'd3);
    check("full_in_ready",  32'(in_ready),  32'd0);
    check("full_out_data",  32'(out_data),  32'h41);
    check("full_out_valid", 32'(out_valid), 32'd1);
    tick();
    check("stall_hold_data", 32'(out_data),  32'h41);
    check("stall_hold_occ",  32'(occupancy), 32'd3);
    out_ready = 1'b1; #1;
    check("full_passthru_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("after_swap_data", 32'(out_data),  32'h42);
    check("after_swap_occ",  32'(occupancy), 32'd3);
    tick();
    check("drain_43", 32'(out_data), 32'h43);
    tick();
    check("drain_44", 32'(out_data), 32'h44);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // A lone item collapses through the empty stages while the sink is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("collapse_occ_c%0d", c),   32'(occupancy), 32'd1);
      check($sformatf("collapse_valid_c%0d", c), 32'(out_valid), (c >= 3) ? 32'd1 : 32'd0);
      if (c >= 3) check($sformatf("collapse_data_c%0d", c), 32'(out_data), 32'h55);
      tick();
    end
    out_ready = 1'b1; tick();
    check("collapse_drained", 32'(out_valid), 32'd0);

    // Flush with two items inside and a competing input: nothing is kept, data registers untouched.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_data = 8'h62; tick();
    check("preflush_occ", 32'(occupancy), 32'd2);
    flush = 1'b1; in_data = 8'h63; #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_occ",       32'(occupancy), 32'd0);
    check("flush_data_kept", 32'(out_data),  32'h55);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("flush_no_capture", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with a full pipe.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h71; tick();
    in_data = 8'h72; tick();
    in_data = 8'h73; tick();
    in_valid = 1'b0;
    check("prerst_occ", 32'(occupancy), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'(RST_VAL));
    check("arst_occ",       32'(occupancy), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h81; out_ready = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data",  32'(out_data),  32'h81);
    tick();

    // Random traffic against a queue model.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rand_occ", 32'(occupancy), 32'(sb.size()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rand_unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          exp_item = sb.pop_front();
          check("rand_data", 32'(out_data), 32'(exp_item));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_item = sb.pop_front();
        check("drain_data", 32'(out_data), 32'(exp_item));
      end
      tick();
    end
    check("rand_all_delivered", 32'(sb.size()), 32'd0);
    check("rand_final_empty",   32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
